// File: rtl/uart_baud_if.sv
// uart_baud_if: run-control, configuration handshake and timing-strobe bundle of the baud controller (optional fractional fields under UART_BAUD_FRAC_EN)
interface uart_baud_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             line_busy;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_err;
    logic             tick_os;
    logic             tick_bit;
    logic [3:0]       phase;
    logic [DIV_W-1:0] div_active;
`ifdef UART_BAUD_FRAC_EN
    logic [3:0]       cfg_frac;
    logic [3:0]       frac_active;
    modport master (
        output en, line_busy, cfg_valid, cfg_div, cfg_frac,
        input  cfg_ready, cfg_done, cfg_err, tick_os, tick_bit, phase, div_active, frac_active
    );
    modport slave (
        input  en, line_busy, cfg_valid, cfg_div, cfg_frac,
        output cfg_ready, cfg_done, cfg_err, tick_os, tick_bit, phase, div_active, frac_active
    );
`else
    modport master (
        output en, line_busy, cfg_valid, cfg_div,
        input  cfg_ready, cfg_done, cfg_err, tick_os, tick_bit, phase, div_active
    );
    modport slave (
        input  en, line_busy, cfg_valid, cfg_div,
        output cfg_ready, cfg_done, cfg_err, tick_os, tick_bit, phase, div_active
    );
`endif
endinterface

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: programmable baud divisor with 16x oversample/bit strobes and safe-point rate switching (UART_BAUD_FRAC_EN adds fractional divisor)
module uart_baud_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 81,
    parameter int MIN_DIV     = 2
) (
    input logic       clk,
    input logic       rst,
    uart_baud_if.slave bus
);
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN = DIV_W'(MIN_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] limit;
    logic [3:0]       phase_q, phase_d;
    logic             tick_os_q, tick_os_d;
    logic             tick_bit_q, tick_bit_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept, bad, apply, wrap, extra;

`ifdef UART_BAUD_FRAC_EN
    logic [3:0] frac_q, frac_d;
    logic [3:0] pend_frac_q, pend_frac_d;
    logic [3:0] acc_q, acc_d;
    logic [4:0] acc_sum;

    // fractional accumulator: a carry on this period's add stretches the period by one clk
    always_comb begin
        acc_sum     = {1'b0, acc_q} + {1'b0, frac_q};
        extra       = acc_sum[4];
        frac_d      = apply ? pend_frac_q : frac_q;
        pend_frac_d = (accept && !bad) ? bus.cfg_frac : pend_frac_q;
        acc_d       = (!bus.en || apply) ? 4'd0 : wrap ? acc_sum[3:0] : acc_q;
    end

    // fractional state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_q      <= 4'd0;
            pend_frac_q <= 4'd0;
            acc_q       <= 4'd0;
        end else begin
            frac_q      <= frac_d;
            pend_frac_q <= pend_frac_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.frac_active = frac_q;
`else
    assign extra = 1'b0;
`endif

    // handshake, safe-point apply, counters and strobes
    always_comb begin
        accept       = bus.cfg_valid && state_q != PEND;
        bad          = bus.cfg_div < MIN;
        apply        = state_q == PEND && !bus.line_busy && (!bus.en || tick_bit_q);
        limit        = extra ? div_active_q : div_active_q - DIV_W'(1);
        wrap         = bus.en && !apply && div_cnt_q == limit;
        div_cnt_d    = (wrap || !bus.en || apply) ? '0 : div_cnt_q + DIV_W'(1);
        phase_d      = (!bus.en || apply) ? 4'd0 : wrap ? phase_q + 4'd1 : phase_q;
        tick_os_d    = wrap;
        tick_bit_d   = wrap && phase_q == 4'd15;
        div_active_d = apply ? pend_div_q : div_active_q;
        pend_div_d   = (accept && !bad) ? bus.cfg_div : pend_div_q;
        err_d        = accept && bad;
        done_d       = apply;
        state_d      = ((state_q == PEND && !apply) || (accept && !bad)) ? PEND : bus.en ? RUN : IDLE;
    end

    // state and timing registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_active_q <= DEF;
            pend_div_q   <= '0;
            div_cnt_q    <= '0;
            phase_q      <= 4'd0;
            tick_os_q    <= 1'b0;
            tick_bit_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_active_q <= div_active_d;
            pend_div_q   <= pend_div_d;
            div_cnt_q    <= div_cnt_d;
            phase_q      <= phase_d;
            tick_os_q    <= tick_os_d;
            tick_bit_q   <= tick_bit_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.cfg_ready  = state_q != PEND;
    assign bus.cfg_done   = done_q;
    assign bus.cfg_err    = err_q;
    assign bus.tick_os    = tick_os_q;
    assign bus.tick_bit   = tick_bit_q;
    assign bus.phase      = phase_q;
    assign bus.div_active = div_active_q;
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: directed and random checks of uart_baud_ctrl against an edge-count reference model
module tb_uart_baud_ctrl;
    localparam int DIV_W = 16;
    localparam int DEF   = 81;
    localparam int MIN   = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    uart_baud_if #(.DIV_W(DIV_W)) bif ();

    uart_baud_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // model: enabled edges since counters last cleared, plus divisor bookkeeping
    int m_n, m_div, m_pdiv, e_phase;
    bit m_pend, e_tos, e_tbit, e_done, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_div = DEF; m_pdiv = 0; m_pend = 0;
        e_tos = 0; e_tbit = 0; e_done = 0; e_err = 0; e_phase = 0;
    endtask

    task automatic check_all();
        chk("tick_os", bif.tick_os, e_tos);
        chk("tick_bit", bif.tick_bit, e_tbit);
        chk("phase", bif.phase, e_phase);
        chk("div_active", bif.div_active, m_div);
        chk("cfg_ready", bif.cfg_ready, !m_pend);
        chk("cfg_done", bif.cfg_done, e_done);
        chk("cfg_err", bif.cfg_err, e_err);
    endtask

    task automatic cyc();
        bit ap, acc;
        int cd;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            cd  = int'(bif.cfg_div);
            ap  = m_pend && !bif.line_busy && (!bif.en || e_tbit);
            acc = bif.cfg_valid && !m_pend;
            e_err  = acc && cd < MIN;
            e_done = ap;
            if (ap) begin m_div = m_pdiv; m_n = 0; m_pend = 0; end
            else if (!bif.en) m_n = 0;
            else m_n++;
            if (acc && cd >= MIN) begin m_pend = 1; m_pdiv = cd; end
            e_tos   = bif.en && m_n > 0 && m_n % m_div == 0;
            e_phase = (m_n / m_div) % 16;
            e_tbit  = e_tos && e_phase == 0;
        end
        #1;
        check_all();
    endtask

    task automatic request(input int d);
        bif.cfg_valid = 1'b1;
        bif.cfg_div   = DIV_W'(d);
        cyc();
        bif.cfg_valid = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bif.en = 1'b0; bif.line_busy = 1'b0; bif.cfg_valid = 1'b0; bif.cfg_div = '0;
`ifdef UART_BAUD_FRAC_EN
        bif.cfg_frac = 4'd0;
`endif
        model_reset();
        #1;
        check_all();
        repeat (3) cyc();
        rst = 1'b0;
        repeat (3) cyc();

        // default rate: first tick latency and bit period
        bif.en = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (!bif.tick_os && k < 200);
        chk("first_tick_latency", k, DEF);
        k = 0;
        while (!bif.tick_bit && k < 2000) begin cyc(); k++; end
        chk("tick_bit_seen", bif.tick_bit, 1);
        k = 0;
        do begin cyc(); k++; end while (!bif.tick_bit && k < 2000);
        chk("tick_bit_period", k, 16 * DEF);

        // below-minimum request is rejected
        request(1);
        chk("err_pulse", bif.cfg_err, 1);
        chk("err_div_kept", bif.div_active, DEF);
        chk("err_ready_kept", bif.cfg_ready, 1);
        cyc();
        chk("err_one_cycle", bif.cfg_err, 0);

        // mid-bit change to 4, applied at the next bit boundary
        k = 0;
        while (bif.phase != 4'd5 && k < 2000) begin cyc(); k++; end
        request(4);
        chk("t2_ready_low", bif.cfg_ready, 0);
        chk("t2_div_old", bif.div_active, DEF);
        k = 0;
        while (!bif.cfg_done && k < 2000) begin cyc(); k++; end
        chk("t2_done_seen", bif.cfg_done, 1);
        chk("t2_div_new", bif.div_active, 4);
        chk("t2_phase_zero", bif.phase, 0);
        k = 0;
        while (!bif.tick_os && k < 20) begin cyc(); k++; end
        k = 0;
        do begin cyc(); k++; end while (!bif.tick_os && k < 20);
        chk("t2_tick_period", k, 4);

        // busy line holds the pending change across three bits
        bif.line_busy = 1'b1;
        request(6);
        k = 0;
        for (int b = 0; b < 3 && k < 1000; ) begin cyc(); k++; if (bif.tick_bit) b++; end
        chk("t3_div_held", bif.div_active, 4);
        chk("t3_ready_low", bif.cfg_ready, 0);
        bif.line_busy = 1'b0;
        k = 0;
        while (!bif.cfg_done && k < 200) begin cyc(); k++; end
        chk("t3_div_new", bif.div_active, 6);

        // disable mid-bit with a request pending applies immediately
        k = 0;
        while (bif.phase != 4'd7 && k < 200) begin cyc(); k++; end
        request(10);
        bif.en = 1'b0;
        cyc();
        chk("t5_phase_zero", bif.phase, 0);
        chk("t5_div_new", bif.div_active, 10);
        chk("t5_done", bif.cfg_done, 1);
        chk("t5_ready", bif.cfg_ready, 1);
        cyc();

        // async reset while a change is pending
        bif.en = 1'b1;
        bif.line_busy = 1'b1;
        request(20);
        repeat (5) cyc();
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_div", bif.div_active, DEF);
        chk("rst_async_ready", bif.cfg_ready, 1);
        chk("rst_async_phase", bif.phase, 0);
        repeat (2) cyc();
        rst = 1'b0;
        bif.line_busy = 1'b0;

        // random traffic: small divisors keep bits short
        request(3);
        for (int i = 0; i < 20000; i++) begin
            bif.en = $urandom_range(0, 99) < 97;
            if ($urandom_range(0, 149) == 0) bif.line_busy = ~bif.line_busy;
            bif.cfg_valid = $urandom_range(0, 199) == 0;
            bif.cfg_div = DIV_W'($urandom_range(0, 6));
            cyc();
        end
        bif.cfg_valid = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
Programmable baud-rate controller that sequences the UART timing path.
- Holds the active divisor and produces the 16x oversample strobe, the 4-bit oversample phase and the per-bit strobe consumed by UART TX/RX.
- Provides a valid/ready configuration port for run-time rate changes. A change is applied only at a safe point: line idle and bit boundary.

Parameters:
- DIV_W, 16, width of divisor registers/counter.
- DEFAULT_DIV, 81, reset divisor: 150 MHz clk / (16 x 115200), rounded down.
- MIN_DIV, 2, smallest legal divisor; smaller requests are rejected.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  run enable; 0 holds counters cleared.
- line_busy  input  1  a TX/RX frame is in progress; defers divisor switch.
- cfg_valid  input  1  divisor change request.
- cfg_div  input  DIV_W  requested divisor, clk cycles per oversample tick.
- cfg_ready  output  1  request accepted when cfg_valid & cfg_ready.
- cfg_done  output  1  one-cycle pulse the cycle after the new divisor takes effect.
- cfg_err  output  1  one-cycle pulse when a request with cfg_div < MIN_DIV is handshaken.
- tick_os  output  1  one-cycle oversample strobe.
- tick_bit  output  1  one-cycle bit strobe, coincident with tick_os at phase 15.
- phase  output  4  oversample index 0..15.
- div_active  output  DIV_W  divisor currently in use.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, div_active=DEFAULT_DIV, div_cnt=0, phase=0.
  - tick_os=tick_bit=cfg_done=cfg_err=0, cfg_ready=1, pend_div=0.
- States:
  - IDLE (en=0, nothing pending).
  - RUN (en=1, nothing pending).
  - PEND (divisor latched, waiting for apply).
- IDLE<->RUN follows en on the next edge.
- Counting, only when en=1:
  - div_cnt runs 0..div_active-1.
  - When div_cnt==div_active-1: div_cnt<=0, tick_os=1, phase<=phase+1 (wraps 15->0).
  - tick_bit=1 on the same cycle as tick_os when phase==15.
  - All strobes are registered, one clk wide.
- en=0 (any state): next edge div_cnt<=0, phase<=0, strobes 0. Mid-bit disable discards the partial bit.
- Handshake:
  - cfg_ready = 1 in IDLE/RUN, 0 in PEND.
  - Accept with cfg_div>=MIN_DIV: pend_div<=cfg_div, go PEND.
  - Accept with cfg_div<MIN_DIV: cfg_err pulses next cycle; state and div_active unchanged.
- PEND: counters keep running on the old divisor.
  - Apply condition: line_busy==0 AND (en==0 OR tick_bit asserted this cycle).
  - On apply edge: div_active<=pend_div, div_cnt<=0, phase<=0.
  - Then state<=RUN if en else IDLE; cfg_done pulses the following cycle.
  - The bit ending at that tick_bit is complete on the old rate. The first new tick_os comes pend_div cycles after apply.
- line_busy=1 holds PEND indefinitely; apply at the first tick_bit after line_busy falls.
- Simultaneous cfg_valid and apply cannot occur, since cfg_ready=0 in PEND.
- Reset mid-PEND discards pend_div and reverts to DEFAULT_DIV.
- Period arithmetic: tick_os period = div_active clk; tick_bit period = 16*div_active clk. No overflow; div_cnt is DIV_W wide.

Optional Feature:
UART_BAUD_FRAC_EN
- Defined:
  - Adds input cfg_frac[3:0], latched and applied with cfg_div, plus output frac_active[3:0]. Reset value of frac_active is 0.
  - A 4-bit accumulator adds frac_active at each tick_os. On carry-out, the next oversample period is div_active+1.
  - Average period = div_active + frac_active/16. Accumulator clears on apply and on en=0.
- Undefined: ports absent; every period is exactly div_active.

Test Plan:
1. Reset then en=1 with DEFAULT_DIV=81 -> first tick_os 81 clk after en sampled; tick_bit every 1296 clk; phase steps 0..15 and wraps.
2. en=1, line_busy=0, cfg_div=4 mid-bit -> cfg_ready drops; old rate continues to next tick_bit; then div_active=4, phase=0, cfg_done pulse next cycle; tick_os period 4.
3. line_busy=1 held across 3 tick_bits with request pending -> no apply; line_busy=0 -> apply at next tick_bit only.
4. cfg_div=1 -> cfg_err one-cycle pulse, div_active stays 81, cfg_ready stays 1.
5. en dropped at phase 7 with request pending (cfg_div=10) -> next edge phase=0, immediate apply, cfg_done pulse, state IDLE; rst asserted mid-PEND -> div_active=81 asynchronously.
6. With UART_BAUD_FRAC_EN: div=4, frac=8 -> tick_os periods alternate 4,5; 16 ticks take 72 clk.
